// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - ID-stage hazard inputs and pipeline stall/flush controls
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       id_op1;
  logic [3:0]       id_op2;
  logic             id_md_start;
  logic             ex_mem_read;
  logic [3:0]       ex_dst;
  logic             branch_taken;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_op1, id_op2, id_md_start, ex_mem_read, ex_dst, branch_taken,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, md_busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_op1, id_op2, id_md_start, ex_mem_read, ex_dst, branch_taken,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use / mult-div R15 / branch-squash stall controller
module hazard_stall_controller #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  bus
);
  localparam int               MW       = $clog2(MD_LATENCY + 1);
  localparam logic [MW-1:0]    MD_LOAD  = MW'(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [MW-1:0]    md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             busy, lu, r15, mdc, stall, accept, squash;

  always_comb begin
    busy   = (md_cnt_q != '0);
    lu     = bus.id_valid & bus.ex_mem_read &
             ((bus.id_op1 == bus.ex_dst) | (bus.id_op2 == bus.ex_dst));
    r15    = bus.id_valid & busy & ((bus.id_op1 == 4'd15) | (bus.id_op2 == 4'd15));
    mdc    = bus.id_valid & busy & bus.id_md_start;
    // Outputs read as zero while reset is held, even with hazardous inputs present.
    squash = bus.branch_taken & ~rst;
    stall  = (lu | r15 | mdc) & ~bus.branch_taken & ~rst;
    accept = bus.id_valid & bus.id_md_start & ~stall & ~bus.branch_taken;

    md_cnt_d = md_cnt_q;
    if (accept) begin
      md_cnt_d = MD_LOAD;
    end else if (busy) begin
      md_cnt_d = md_cnt_q - MW'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_stall    = stall;
  assign bus.ifid_stall  = stall;
  assign bus.idex_bubble = stall | squash;
  assign bus.ifid_flush  = squash;
  assign bus.md_busy     = busy;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;
  localparam int L     = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct {
    logic pc_stall;
    logic ifid_stall;
    logic idex_bubble;
    logic ifid_flush;
    logic md_busy;
    int   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hazard_stall_controller_if #(.CNT_W(CW)) bus();

  hazard_stall_controller #(.MD_LATENCY(L), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   busy_until = 0;
  int   total      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Monitor: compares the presented outputs a little after the stimulus settles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_stall",    32'(bus.pc_stall),    32'(e.pc_stall));
        chk("ifid_stall",  32'(bus.ifid_stall),  32'(e.ifid_stall));
        chk("idex_bubble", 32'(bus.idex_bubble), 32'(e.idex_bubble));
        chk("ifid_flush",  32'(bus.ifid_flush),  32'(e.ifid_flush));
        chk("md_busy",     32'(bus.md_busy),     32'(e.md_busy));
        chk("stall_cnt",   32'(bus.stall_cnt),   32'(e.cnt));
      end
    end
  end

  // One cycle: drive inputs, predict outputs from the rules, then advance the model at the edge.
  task automatic step(input logic v, input logic [3:0] o1, input logic [3:0] o2,
                      input logic mds, input logic mr, input logic [3:0] dst,
                      input logic bt, input logic r);
    exp_t e;
    logic busy, hz, stall, acc;
    @(negedge clk);
    bus.id_valid = v; bus.id_op1 = o1; bus.id_op2 = o2; bus.id_md_start = mds;
    bus.ex_mem_read = mr; bus.ex_dst = dst; bus.branch_taken = bt; rst = r;
    if (r) begin
      busy_until = 0;
      total      = 0;
    end
    busy  = !r && (cyc < busy_until);
    hz    = (v && mr && (o1 == dst || o2 == dst)) ||
            (v && busy && (o1 == 4'd15 || o2 == 4'd15)) ||
            (v && busy && mds);
    stall = hz && !bt && !r;
    acc   = !r && v && mds && !stall && !bt;
    e.pc_stall    = stall;
    e.ifid_stall  = stall;
    e.idex_bubble = stall || (bt && !r);
    e.ifid_flush  = bt && !r;
    e.md_busy     = busy;
    e.cnt         = (total > CMAX) ? CMAX : total;
    exp_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      if (stall) total++;
      if (acc) busy_until = cyc + 1 + L;
    end
    cyc++;
  endtask

  function automatic logic [3:0] pick_reg();
    if ($urandom % 4 == 0) return 4'd15;
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    bus.id_valid = 1'b0; bus.id_op1 = '0; bus.id_op2 = '0; bus.id_md_start = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_dst = '0; bus.branch_taken = 1'b0;
    // Reset state, including hazardous inputs held during reset
    step(1, 4'd3, 4'd3, 0, 1, 4'd3, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // T1: load-use for one cycle, then clear
    step(1, 4'd1, 4'd3, 0, 1, 4'd3, 0, 0);
    step(1, 4'd1, 4'd3, 0, 0, 4'd3, 0, 0);
    // T2: accept mult/div, then R15 reader stalls until release
    step(1, 4'd1, 4'd2, 1, 0, 4'd0, 0, 0);
    for (int i = 0; i < L + 2; i++) step(1, 4'd15, 4'd2, 0, 0, 4'd0, 0, 0);
    // T3: load-use squashed by taken branch
    step(1, 4'd3, 4'd0, 0, 1, 4'd3, 1, 0);
    // Squashed mult/div must not be accepted
    step(1, 4'd1, 4'd2, 1, 0, 4'd0, 1, 0);
    step(1, 4'd15, 4'd2, 0, 0, 4'd0, 0, 0);
    // T4: second mult/div held off while busy, then accepted
    step(1, 4'd1, 4'd2, 1, 0, 4'd0, 0, 0);
    for (int i = 0; i < L + 1; i++) step(1, 4'd1, 4'd2, 1, 0, 4'd0, 0, 0);
    for (int i = 0; i < L + 1; i++) step(0, 4'd15, 4'd15, 0, 0, 4'd0, 0, 0);
    // Load and busy mult/div overlapping
    step(1, 4'd1, 4'd2, 1, 0, 4'd0, 0, 0);
    step(1, 4'd15, 4'd5, 0, 1, 4'd5, 0, 0);
    step(1, 4'd15, 4'd5, 0, 0, 4'd5, 0, 0);
    // T5: async reset with md counter at 2
    for (int i = 0; i < L + 1; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 4'd1, 4'd2, 1, 0, 4'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 4'd15, 4'd2, 0, 0, 4'd0, 0, 1);
    step(1, 4'd15, 4'd2, 0, 0, 4'd0, 0, 1);
    step(1, 4'd15, 4'd2, 0, 0, 4'd0, 0, 0);
    // T6: saturate the stall counter
    for (int i = 0; i < CMAX + 4; i++) step(1, 4'd0, 4'd3, 0, 1, 4'd3, 0, 0);
    // Randomised traffic
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 8) != 0, pick_reg(), pick_reg(), ($urandom % 5) == 0,
           ($urandom % 3) == 0, 4'($urandom_range(0, 3)), ($urandom % 8) == 0,
           ($urandom % 150) == 0);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
